memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/memory_controller.sv | 172 +++++++++++++++++
 tb/tb_memory_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// Memory controller: takes one CPU read/write from IDLE and runs it on the memory port with a bounded ack wait.
// Latency: accept-to-done >= 2 cycles; Read/Write arriving while busy is dropped (no queuing, no backpressure).
module memory_controller #(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              MARin,
   input  logic [31:0]       BusMuxOut,
   input  logic              Read,
   input  logic              Write,
   input  logic [31:0]       MDRdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       Mdatain,
   output logic              mdr_load,
   output logic              busy,
   output logic              done,
   output logic              timeout_err
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Everything the in-flight access needs, frozen at acceptance.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } snap_t;

   state_t            state_q = IDLE;
   state_t            state_d;
   snap_t             snap_q = '0;
   snap_t             snap_d;
   logic [ADDR_W-1:0] mar_q = '0;
   logic [ADDR_W-1:0] mar_d;
   logic [CNT_W-1:0]  cnt_q = '0;
   logic [CNT_W-1:0]  cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [31:0]       mdatain_q = '0;
   logic [31:0]       mdatain_d;
   logic              mem_req_q = 1'b0;
   logic              mem_req_d;
   logic              mem_we_q = 1'b0;
   logic              mem_we_d;
   logic              mdr_load_q = 1'b0;
   logic              mdr_load_d;
   logic              busy_q = 1'b0;
   logic              busy_d;
   logic              done_q = 1'b0;
   logic              done_d;
   logic              terr_q = 1'b0;
   logic              terr_d;

   logic              unused_bus;
   assign unused_bus = ^BusMuxOut[31:ADDR_W];

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      mar_d      = mar_q;
      cnt_d      = cnt_q;
      mdatain_d  = mdatain_q;
      terr_d     = terr_q;
      mem_req_d  = 1'b0;
      mem_we_d   = 1'b0;
      mdr_load_d = 1'b0;
      done_d     = 1'b0;

      // MAR loads in every state; the snapshot below still sees the old value.
      if (MARin) begin
         mar_d = BusMuxOut[ADDR_W-1:0];
      end

      case (state_q)
         IDLE: begin
            if (Read || Write) begin
               state_d      = ACCESS;
               snap_d.we    = ~Read;
               snap_d.addr  = mar_q;
               snap_d.wdata = MDRdata;
               cnt_d        = '0;
               terr_d       = 1'b0;
               mem_req_d    = 1'b1;
               mem_we_d     = ~Read;
            end
         end
         ACCESS: begin
            cnt_d = cnt_inc;
            if (mem_ack) begin
               state_d    = DONE;
               done_d     = 1'b1;
               mdr_load_d = ~snap_q.we;
               if (!snap_q.we) begin
                  mdatain_d = mem_rdata;
               end
            end else if (cnt_inc == TIMEOUT_C) begin
               state_d = DONE;
               done_d  = 1'b1;
               terr_d  = 1'b1;
            end else begin
               mem_req_d = 1'b1;
               mem_we_d  = snap_q.we;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q    <= IDLE;
         snap_q     <= '0;
         mar_q      <= '0;
         cnt_q      <= '0;
         mdatain_q  <= '0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mdr_load_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         mar_q      <= mar_d;
         cnt_q      <= cnt_d;
         mdatain_q  <= mdatain_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
         mdr_load_q <= mdr_load_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         terr_q     <= terr_d;
      end
   end

   assign mem_addr    = snap_q.addr;
   assign mem_wdata   = snap_q.wdata;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign Mdatain     = mdatain_q;
   assign mdr_load    = mdr_load_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = terr_q;

   a_we_needs_req : assert property (@(posedge clock) mem_we |-> mem_req);
   a_done_no_req  : assert property (@(posedge clock) done |-> !mem_req);

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: per-cycle compare against a transaction-level model plus literal checks.
module tb_memory_controller;

   localparam int AW = 9;
   localparam int TO = 15;

   logic          clock = 1'b0;
   logic          clear = 1'b0;
   logic          MARin = 1'b0;
   logic [31:0]   BusMuxOut = '0;
   logic          Read = 1'b0;
   logic          Write = 1'b0;
   logic [31:0]   MDRdata = '0;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_req;
   logic          mem_we;
   logic          mem_ack = 1'b0;
   logic [31:0]   mem_rdata = '0;
   logic [31:0]   Mdatain;
   logic          mdr_load;
   logic          busy;
   logic          done;
   logic          timeout_err;

   always #5 clock = ~clock;

   memory_controller #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clock(clock), .clear(clear), .MARin(MARin), .BusMuxOut(BusMuxOut),
      .Read(Read), .Write(Write), .MDRdata(MDRdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Mdatain(Mdatain), .mdr_load(mdr_load),
      .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: an access is a countdown of remaining request cycles.
   logic [AW-1:0] m_mar = '0;
   bit            m_in_access = 1'b0;
   bit            m_finishing = 1'b0;
   bit            m_op_write = 1'b0;
   int            m_left = 0;
   logic [AW-1:0] e_addr = '0;
   logic [31:0]   e_wdata = '0;
   logic [31:0]   e_mdatain = '0;
   bit            e_req = 1'b0, e_we = 1'b0, e_mdr_load = 1'b0;
   bit            e_busy = 1'b0, e_done = 1'b0, e_terr = 1'b0;

   always @(posedge clock) begin
      if (!clear) begin
         m_mar = '0; m_in_access = 0; m_finishing = 0; m_op_write = 0; m_left = 0;
         e_addr = '0; e_wdata = '0; e_mdatain = '0; e_terr = 0;
         e_done = 0; e_mdr_load = 0;
      end else begin
         e_done = 0;
         e_mdr_load = 0;
         if (m_finishing) begin
            m_finishing = 0;
         end else if (m_in_access) begin
            if (mem_ack) begin
               m_in_access = 0; m_finishing = 1; e_done = 1;
               if (!m_op_write) begin
                  e_mdatain = mem_rdata;
                  e_mdr_load = 1;
               end
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_in_access = 0; m_finishing = 1; e_done = 1; e_terr = 1;
               end
            end
         end else if (Read || Write) begin
            m_in_access = 1;
            m_left = TO;
            m_op_write = !Read;
            e_addr = m_mar;
            e_wdata = MDRdata;
            e_terr = 0;
         end
         if (MARin) m_mar = BusMuxOut[AW-1:0];
      end
      e_req  = m_in_access;
      e_we   = m_in_access && m_op_write;
      e_busy = m_in_access || m_finishing;
   end

   always @(negedge clock) begin
      chk("cyc mem_req",     32'(mem_req),     32'(e_req));
      chk("cyc mem_we",      32'(mem_we),      32'(e_we));
      chk("cyc mem_addr",    32'(mem_addr),    32'(e_addr));
      chk("cyc mem_wdata",   mem_wdata,        e_wdata);
      chk("cyc Mdatain",     Mdatain,          e_mdatain);
      chk("cyc mdr_load",    32'(mdr_load),    32'(e_mdr_load));
      chk("cyc busy",        32'(busy),        32'(e_busy));
      chk("cyc done",        32'(done),        32'(e_done));
      chk("cyc timeout_err", 32'(timeout_err), 32'(e_terr));
   end

   task automatic tick();
      @(posedge clock);
      #2;
      MARin = 1'b0; Read = 1'b0; Write = 1'b0; mem_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #1;
      chk("init mem_req", 32'(mem_req), 32'h0);
      chk("init Mdatain", Mdatain, 32'h0);
      tick(); tick();
      clear = 1'b1;
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset timeout_err", 32'(timeout_err), 32'h0);

      // Read at 0x1A5, ack on first ACCESS cycle
      MARin = 1'b1; BusMuxOut = 32'h0000_01A5;
      tick();
      Read = 1'b1;
      tick();
      chk("rd1 mem_req", 32'(mem_req), 32'h1);
      chk("rd1 mem_addr", 32'(mem_addr), 32'h1A5);
      chk("rd1 done early", 32'(done), 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("rd1 done", 32'(done), 32'h1);
      chk("rd1 mdr_load", 32'(mdr_load), 32'h1);
      chk("rd1 Mdatain", Mdatain, 32'hDEAD_BEEF);
      chk("rd1 mem_req off", 32'(mem_req), 32'h0);
      tick();
      chk("rd1 done pulse", 32'(done), 32'h0);
      chk("rd1 idle", 32'(busy), 32'h0);

      // Write at 0x010, ack after 3 wait cycles
      MARin = 1'b1; BusMuxOut = 32'h0000_0010;
      tick();
      Write = 1'b1; MDRdata = 32'h1234_5678;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("wr mem_we", 32'(mem_we), 32'h1);
         chk("wr mem_wdata", mem_wdata, 32'h1234_5678);
         tick();
      end
      chk("wr mem_req", 32'(mem_req), 32'h1);
      chk("wr mem_addr", 32'(mem_addr), 32'h010);
      mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      tick();
      chk("wr done", 32'(done), 32'h1);
      chk("wr mdr_load", 32'(mdr_load), 32'h0);
      chk("wr mem_we off", 32'(mem_we), 32'h0);
      chk("wr Mdatain kept", Mdatain, 32'hDEAD_BEEF);
      tick();

      // Read with no ack: timeout after TO request cycles
      Read = 1'b1;
      tick();
      n = 0;
      while (mem_req === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk("to req cycles", 32'(n), 32'd15);
      chk("to done", 32'(done), 32'h1);
      chk("to timeout_err", 32'(timeout_err), 32'h1);
      chk("to mdr_load", 32'(mdr_load), 32'h0);
      chk("to Mdatain kept", Mdatain, 32'hDEAD_BEEF);
      tick();
      chk("to sticky", 32'(timeout_err), 32'h1);
      Read = 1'b1;
      tick();
      chk("to cleared", 32'(timeout_err), 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      chk("to next rd", Mdatain, 32'hCAFE_F00D);
      tick();

      // Read+Write together, then MARin and Read during ACCESS
      Read = 1'b1; Write = 1'b1; MDRdata = 32'hAAAA_5555;
      tick();
      chk("rw mem_we", 32'(mem_we), 32'h0);
      chk("rw mem_addr", 32'(mem_addr), 32'h010);
      for (int i = 0; i < 3; i++) begin
         MARin = 1'b1; BusMuxOut = 32'h0000_00FF; Read = 1'b1;
         tick();
         chk("rw addr stable", 32'(mem_addr), 32'h010);
      end
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      tick();
      chk("rw done", 32'(done), 32'h1);
      chk("rw Mdatain", Mdatain, 32'h1111_2222);
      tick();
      tick();
      chk("rw no 2nd access", 32'(mem_req), 32'h0);

      // MARin and Read in the same IDLE cycle use the old MAR
      MARin = 1'b1; BusMuxOut = 32'h0000_0055; Read = 1'b1;
      tick();
      chk("old mar addr", 32'(mem_addr), 32'h0FF);
      mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
      tick();
      tick();

      // Stray ack while idle
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
      tick();
      chk("idle ack done", 32'(done), 32'h0);
      chk("idle ack Mdatain", Mdatain, 32'h3333_4444);

      // clear on 2nd ACCESS cycle aborts
      Read = 1'b1;
      tick();
      chk("abort addr", 32'(mem_addr), 32'h055);
      tick();
      clear = 1'b0;
      tick();
      chk("abort mem_req", 32'(mem_req), 32'h0);
      chk("abort done", 32'(done), 32'h0);
      chk("abort busy", 32'(busy), 32'h0);
      chk("abort Mdatain", Mdatain, 32'h0);
      chk("abort mem_addr", 32'(mem_addr), 32'h0);
      clear = 1'b1;
      tick();
      chk("abort no done", 32'(done), 32'h0);

      // Ack on the timeout cycle wins
      Read = 1'b1;
      tick();
      chk("race mem_addr", 32'(mem_addr), 32'h0);
      for (int i = 0; i < 14; i++) tick();
      chk("race still req", 32'(mem_req), 32'h1);
      mem_ack = 1'b1; mem_rdata = 32'h0F0F_0F0F;
      tick();
      chk("race done", 32'(done), 32'h1);
      chk("race no err", 32'(timeout_err), 32'h0);
      chk("race mdr_load", 32'(mdr_load), 32'h1);
      chk("race Mdatain", Mdatain, 32'h0F0F_0F0F);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
